// File: rtl/result_pkg.sv
// Shared types for the result-stage arbiter: request payload, source tag and arbitration state.
package result_pkg;

   typedef enum logic [1:0] {
      SIGN_OPERAND_A = 2'd0,
      SIGN_OPERAND_B = 2'd1,
      SIGN_XOR       = 2'd2,
      SIGN_ZERO      = 2'd3
   } sign_select_t;

   typedef enum logic [1:0] {
      EXP_DATAPATH = 2'd0,
      EXP_NORM     = 2'd1,
      EXP_ZERO     = 2'd2,
      EXP_MAX      = 2'd3
   } exponent_select_t;

   typedef enum logic [1:0] {
      FRAC_MSB_DATAPATH = 2'd0,
      FRAC_MSB_ZERO     = 2'd1,
      FRAC_MSB_ONE      = 2'd2,
      FRAC_MSB_NAN      = 2'd3
   } fraction_msb_select_t;

   typedef enum logic [1:0] {
      FRAC_LSBS_DATAPATH = 2'd0,
      FRAC_LSBS_ZERO     = 2'd1,
      FRAC_LSBS_ONES     = 2'd2,
      FRAC_LSBS_NAN      = 2'd3
   } fraction_lsbs_select_t;

   typedef struct packed {
      logic                  check_result;
      sign_select_t          sign_select;
      exponent_select_t      exponent_select;
      fraction_msb_select_t  fraction_msb_select;
      fraction_lsbs_select_t fraction_lsbs_select;
      logic                  sign;
      logic [9:0]            exponent;
      logic [31:0]           fraction;
   } result_req_t;

   typedef enum logic {
      SRC_PIPE = 1'b0,
      SRC_DIV  = 1'b1
   } src_t;

   typedef enum logic {
      FAVOR_PIPE = 1'b0,
      FAVOR_DIV  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/result_output_reg.sv
// One-entry output register between the arbiter and the result selecter.
module result_output_reg
   import result_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        load_en_i,
   input  logic        flush_i,
   input  logic        win_valid_i,
   input  result_req_t win_req_i,
   input  src_t        win_src_i,
   output logic        out_valid_o,
   output result_req_t out_req_o,
   output src_t        out_src_o
);

   logic        out_valid_q;
   result_req_t out_req_q;
   src_t        out_src_q;

   // Payload only moves on a real load, so a stalled entry stays bit-stable.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         out_valid_q <= 1'b0;
         out_req_q   <= '0;
         out_src_q   <= SRC_PIPE;
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
      end else if (load_en_i) begin
         out_valid_q <= win_valid_i;
         if (win_valid_i) begin
            out_req_q <= win_req_i;
            out_src_q <= win_src_i;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_req_o   = out_req_q;
   assign out_src_o   = out_src_q;

endmodule

// File: rtl/result_stage_arbiter.sv
// Arbitrates PIPE and DIV results into the shared result stage; PIPE has priority,
// a starvation counter bounds how long DIV can be held off.
module result_stage_arbiter
   import result_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        pipe_valid,
   output logic        pipe_ready,
   input  result_req_t pipe_req,
   input  logic        div_valid,
   output logic        div_ready,
   input  result_req_t div_req,
   output logic        out_valid,
   input  logic        out_ready,
   output result_req_t out_req,
   output src_t        out_source
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_LIMIT);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   logic        load_en;
   logic        pipe_win, div_win, win_valid;
   result_req_t win_req;
   src_t        win_src;

   always_comb begin
      load_en  = (!out_valid || out_ready) && !flush && reset_n;
      pipe_win = 1'b0;
      div_win  = 1'b0;
      unique case (state_q)
         FAVOR_PIPE: begin
            if (pipe_valid)     pipe_win = 1'b1;
            else if (div_valid) div_win  = 1'b1;
         end
         FAVOR_DIV: begin
            if (div_valid)       div_win  = 1'b1;
            else if (pipe_valid) pipe_win = 1'b1;
         end
         default: ;
      endcase
      win_valid  = pipe_win || div_win;
      win_req    = div_win ? div_req : pipe_req;
      win_src    = div_win ? SRC_DIV : SRC_PIPE;
      pipe_ready = load_en && pipe_win;
      div_ready  = load_en && div_win;
   end

   // Switching on the next count value lets DIV win right after its STARVE_LIMIT-th loss.
   always_comb begin
      starve_cnt_d = '0;
      state_d      = state_q;
      if (flush) begin
         starve_cnt_d = '0;
         state_d      = FAVOR_PIPE;
      end else begin
         if (div_valid && !div_ready) begin
            starve_cnt_d = (starve_cnt_q == CntMax) ? CntMax : starve_cnt_q + 1'b1;
         end
         unique case (state_q)
            FAVOR_PIPE: if (starve_cnt_d == CntMax) state_d = FAVOR_DIV;
            FAVOR_DIV:  if (div_ready || !div_valid) state_d = FAVOR_PIPE;
            default:    state_d = FAVOR_PIPE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= FAVOR_PIPE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   result_output_reg u_output_reg (
      .clk_i       (clk),
      .reset_ni    (reset_n),
      .load_en_i   (load_en),
      .flush_i     (flush),
      .win_valid_i (win_valid),
      .win_req_i   (win_req),
      .win_src_i   (win_src),
      .out_valid_o (out_valid),
      .out_req_o   (out_req),
      .out_src_o   (out_source)
   );

endmodule

// File: tb/tb_result_stage_arbiter.sv
// Scoreboard bench: model predicts readies and pushes accepted requests; a monitor checks the output.
module tb_result_stage_arbiter;
   import result_pkg::*;

   localparam int unsigned Limit = 4;

   typedef struct packed {
      src_t        src;
      result_req_t req;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        pipe_valid = 1'b0;
   logic        pipe_ready;
   result_req_t pipe_req = '0;
   logic        div_valid = 1'b0;
   logic        div_ready;
   result_req_t div_req = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   result_req_t out_req;
   src_t        out_source;

   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];
   int   losses = 0;

   always #5 clk = ~clk;

   result_stage_arbiter #(
      .STARVE_LIMIT (Limit)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .pipe_valid (pipe_valid),
      .pipe_ready (pipe_ready),
      .pipe_req   (pipe_req),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_req    (div_req),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_req    (out_req),
      .out_source (out_source)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic result_req_t rnd_req();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return result_req_t'(r[$bits(result_req_t)-1:0]);
   endfunction

   // Drive one cycle, then predict readies and record what gets accepted.
   task automatic cyc(input logic rn, input logic fl, input logic pv, input logic dv,
                      input logic ordy, input result_req_t preq, input result_req_t dreq);
      bit   ld, dwin, pwin, exp_pr, exp_dr;
      exp_t e;
      @(negedge clk);
      reset_n    = rn;
      flush      = fl;
      pipe_valid = pv;
      div_valid  = dv;
      out_ready  = ordy;
      pipe_req   = preq;
      div_req    = dreq;
      #2;
      ld     = rn && !fl && (sb.size() == 0 || ordy);
      dwin   = dv && (!pv || losses >= Limit);
      pwin   = pv && !dwin;
      exp_pr = ld && pwin;
      exp_dr = ld && dwin;
      chk("pipe_ready", 64'(pipe_ready), 64'(exp_pr));
      chk("div_ready", 64'(div_ready), 64'(exp_dr));
      if (!rn || fl) begin
         sb.delete();
         losses = 0;
      end else begin
         if (exp_pr) begin
            e.src = SRC_PIPE;
            e.req = preq;
            sb.push_back(e);
         end else if (exp_dr) begin
            e.src = SRC_DIV;
            e.req = dreq;
            sb.push_back(e);
         end
         if (dv && !exp_dr) losses = (losses < Limit) ? losses + 1 : Limit;
         else losses = 0;
      end
   endtask

   always begin
      @(negedge clk);
      #1;
      if (mon_en) begin
         chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
         if (out_valid && sb.size() != 0) begin
            chk("out_req", 64'(out_req), 64'(sb[0].req));
            chk("out_source", 64'(out_source), 64'(sb[0].src));
            if (out_ready && !flush) void'(sb.pop_front());
         end
      end
   end

   initial begin
      result_req_t r;

      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());
      mon_en = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());
      chk("reset_out_req", 64'(out_req), 64'd0);
      chk("reset_out_source", 64'(out_source), 64'(SRC_PIPE));

      for (int i = 1; i <= 8; i++) begin
         r = rnd_req();
         r.exponent = 10'(i);
         cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, r, rnd_req());
      end

      repeat (20) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());

      r = rnd_req();
      r.fraction = 32'h00C0_0000;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, r, rnd_req());
      repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rnd_req(), rnd_req());
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());

      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd_req(), rnd_req());
      repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());
      repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, rnd_req(), rnd_req());

      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd_req(), rnd_req());
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rnd_req(), rnd_req());
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd_req(), rnd_req());
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, rnd_req(), rnd_req());

      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), rnd_req(), rnd_req());
      end

      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rnd_req(), rnd_req());
      @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
